mem_access_ctrl: RTL and testbench

- MEM-stage data-memory initiator. Issues read/write requests to the data cache for the load/store currently in MEM and stalls the pipeline until the response arrives.
- Holds the response until the MEM/WB stage register accepts it.
- Produces the raw read word, byte shift, read/write masks, aligned write data and the misalignment trap that the MEM/WB register captures. It is the producing end of that register's memory-side inputs.

---
 rtl/mem_access_ctrl_pkg.sv | 49 ++++
 rtl/mem_access_ctrl_if.sv | 26 ++
 rtl/mem_access_ctrl_mask_gen.sv | 38 +++
 rtl/mem_access_ctrl.sv | 157 +++++++++++++++
 tb/tb_mem_access_ctrl.sv | 317 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_access_ctrl_pkg.sv
// Shared types for the MEM-stage data-memory initiator: load/store funct3
// encodings, controller state, and the byte-lane helpers used by the mask logic.
package mem_access_ctrl_pkg;

  typedef enum logic [2:0] {
    LF3_LB  = 3'b000,
    LF3_LH  = 3'b001,
    LF3_LW  = 3'b010,
    LF3_LBU = 3'b100,
    LF3_LHU = 3'b101
  } load_funct3_t;

  typedef enum logic [2:0] {
    SF3_SB = 3'b000,
    SF3_SH = 3'b001,
    SF3_SW = 3'b010
  } store_funct3_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } mem_ctrl_state_t;

  // funct3[1:0] carries the access size; anything that is not byte/half is a word
  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;

  function automatic logic [3:0] access_mask(input logic [1:0] size, input logic [1:0] off);
    logic [3:0] m;
    case (size)
      SIZE_BYTE: m = 4'b0001 << off;
      SIZE_HALF: m = 4'b0011 << off;
      default:   m = 4'b1111;
    endcase
    return m;
  endfunction

  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
    logic mis;
    case (size)
      SIZE_BYTE: mis = 1'b0;
      SIZE_HALF: mis = off[0];
      default:   mis = |off;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/mem_access_ctrl_if.sv
// Data-cache request/response bus between the MEM-stage initiator and the cache.
//
// Handshake: a request is a level. dmem_read or dmem_write stays high, with
// address/wdata/byte_enable stable, from the issue cycle until and including
// the cycle in which the cache pulses dmem_resp for exactly one cycle; that
// pulse completes the transfer and dmem_rdata is valid only in that cycle.
// The initiator drops the request the cycle after dmem_resp.
interface mem_access_ctrl_if;
  logic        dmem_read;
  logic        dmem_write;
  logic [31:0] dmem_address;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_byte_enable;
  logic [31:0] dmem_rdata;
  logic        dmem_resp;

  modport master (
    output dmem_read, dmem_write, dmem_address, dmem_wdata, dmem_byte_enable,
    input  dmem_rdata, dmem_resp
  );

  modport slave (
    input  dmem_read, dmem_write, dmem_address, dmem_wdata, dmem_byte_enable,
    output dmem_rdata, dmem_resp
  );
endinterface

// File: rtl/mem_access_ctrl_mask_gen.sv
// Combinational byte-lane logic: read/write masks, misalignment detect,
// word-aligned address and lane-shifted store data.
module mem_access_ctrl_mask_gen
  import mem_access_ctrl_pkg::*;
(
  input  logic [2:0]  i_funct3,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_store_data,
  input  logic        i_mem_read,
  input  logic        i_mem_write,
  output logic [3:0]  o_rmask,
  output logic [3:0]  o_wmask,
  output logic        o_misaligned,
  output logic [31:0] o_aligned_addr,
  output logic [31:0] o_wdata,
  output logic [1:0]  o_bit_shift
);

  logic [1:0] w_off;
  logic [3:0] w_mask;
  // Sign/zero extension (funct3[2]) is applied at WB, not here
  logic       w_unused_sign;

  assign w_unused_sign = i_funct3[2];
  assign w_off         = i_addr[1:0];

  // Lane masks are suppressed entirely for misaligned accesses
  always_comb begin
    w_mask         = access_mask(i_funct3[1:0], w_off);
    o_misaligned   = is_misaligned(i_funct3[1:0], w_off);
    o_rmask        = (i_mem_read  && !o_misaligned) ? w_mask : 4'b0000;
    o_wmask        = (i_mem_write && !o_misaligned) ? w_mask : 4'b0000;
    o_aligned_addr = {i_addr[31:2], 2'b00};
    o_wdata        = i_store_data << {w_off, 3'b000};
    o_bit_shift    = w_off;
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// MEM-stage data-memory initiator: issues one cache request per load/store,
// stalls the pipe until the response, then holds the read word until the
// MEM/WB register takes it.
module mem_access_ctrl
  import mem_access_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_mem_valid,
  input  logic              i_mem_read,
  input  logic              i_mem_write,
  input  logic [2:0]        i_funct3,
  input  logic [31:0]       i_addr,
  input  logic [31:0]       i_store_data,
  input  logic              i_pipe_advance,
  mem_access_ctrl_if.master dmem,
  output logic              o_stall,
  output logic [31:0]       o_mem_rdata,
  output logic [1:0]        o_bit_shift,
  output logic [3:0]        o_rmask,
  output logic [3:0]        o_wmask,
  output logic              o_trap,
  output logic              o_timeout_err,
  output mem_ctrl_state_t   o_state
);

  localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

  mem_ctrl_state_t r_state, w_next_state;

  logic [31:0]      r_addr, r_wdata, r_rdata;
  logic [3:0]       r_be;
  logic             r_rd, r_wr, r_timeout_err;
  logic [CNT_W-1:0] r_wait_cnt, w_cnt_inc;

  logic [3:0]  w_rmask, w_wmask;
  logic        w_misaligned, w_access, w_go, w_issue;
  logic [31:0] w_aligned_addr, w_shift_wdata;

  logic        w_dmem_read, w_dmem_write, w_stall;
  logic [31:0] w_dmem_address, w_dmem_wdata;
  logic [3:0]  w_dmem_be;

  mem_access_ctrl_mask_gen u_mask_gen (
    .i_funct3       (i_funct3),
    .i_addr         (i_addr),
    .i_store_data   (i_store_data),
    .i_mem_read     (i_mem_read),
    .i_mem_write    (i_mem_write),
    .o_rmask        (w_rmask),
    .o_wmask        (w_wmask),
    .o_misaligned   (w_misaligned),
    .o_aligned_addr (w_aligned_addr),
    .o_wdata        (w_shift_wdata),
    .o_bit_shift    (o_bit_shift)
  );

  // rst is folded into go so a live MEM op cannot leak a request while reset is held
  assign w_access  = i_mem_read | i_mem_write;
  assign w_go      = rst & i_mem_valid & w_access & ~w_misaligned;
  assign w_issue   = (r_state == IDLE) & w_go;
  assign w_cnt_inc = r_wait_cnt + 1'b1;

  // Next state and request/stall outputs; the issue cycle drives straight from the inputs
  always_comb begin
    w_next_state   = r_state;
    w_dmem_read    = 1'b0;
    w_dmem_write   = 1'b0;
    w_dmem_address = r_addr;
    w_dmem_wdata   = r_wdata;
    w_dmem_be      = r_be;
    w_stall        = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_go) begin
          w_dmem_read    = i_mem_read;
          w_dmem_write   = i_mem_write;
          w_dmem_address = w_aligned_addr;
          w_dmem_wdata   = w_shift_wdata;
          w_dmem_be      = i_mem_write ? w_wmask : 4'b1111;
          w_stall        = 1'b1;
          w_next_state   = BUSY;
        end
      end
      BUSY: begin
        w_dmem_read  = r_rd;
        w_dmem_write = r_wr;
        w_stall      = 1'b1;
        if (dmem.dmem_resp) w_next_state = DONE;
      end
      DONE: begin
        if (i_pipe_advance) w_next_state = IDLE;
      end
      default: w_next_state = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_next_state;
  end

  // Latch the request at issue so BUSY holds it independent of the inputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_addr  <= '0;
      r_wdata <= '0;
      r_be    <= '0;
      r_rd    <= 1'b0;
      r_wr    <= 1'b0;
    end else if (w_issue) begin
      r_addr  <= w_dmem_address;
      r_wdata <= w_dmem_wdata;
      r_be    <= w_dmem_be;
      r_rd    <= i_mem_read;
      r_wr    <= i_mem_write;
    end
  end

  // Capture the raw response word; stores capture too, WB ignores it
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                 r_rdata <= '0;
    else if (r_state == BUSY && dmem.dmem_resp) r_rdata <= dmem.dmem_rdata;
  end

  // Watchdog: count BUSY cycles, flag once TIMEOUT of them have elapsed
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wait_cnt    <= '0;
      r_timeout_err <= 1'b0;
    end else if (w_issue) begin
      r_wait_cnt <= '0;
    end else if (r_state == BUSY) begin
      if (r_wait_cnt != CNT_MAX) r_wait_cnt <= w_cnt_inc;
      if (TIMEOUT != 0 && r_wait_cnt != CNT_MAX && w_cnt_inc == CNT_MAX) r_timeout_err <= 1'b1;
    end
  end

  assign dmem.dmem_read        = w_dmem_read;
  assign dmem.dmem_write       = w_dmem_write;
  assign dmem.dmem_address     = w_dmem_address;
  assign dmem.dmem_wdata       = w_dmem_wdata;
  assign dmem.dmem_byte_enable = w_dmem_be;

  assign o_stall       = w_stall;
  assign o_mem_rdata   = r_rdata;
  assign o_rmask       = w_rmask;
  assign o_wmask       = w_wmask;
  assign o_trap        = i_mem_valid & w_access & w_misaligned;
  assign o_timeout_err = r_timeout_err;
  assign o_state       = r_state;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: directed cases, randomized load/store traffic
// with a timeline model of each transaction, watchdog and async reset.
module tb_mem_access_ctrl;
  import mem_access_ctrl_pkg::*;

  localparam int TMO = 4;

  // ---------------- clock / reset / DUT ----------------
  logic clk = 1'b0;
  logic rst;
  logic mem_valid, mem_read, mem_write, pipe_advance;
  logic [2:0]  funct3;
  logic [31:0] addr, store_data;
  logic        stall, trap, timeout_err;
  logic [31:0] mem_rdata;
  logic [1:0]  bit_shift;
  logic [3:0]  rmask, wmask;
  mem_ctrl_state_t state;

  mem_access_ctrl_if dmem_if();

  mem_access_ctrl #(.TIMEOUT(TMO)) dut (
    .clk           (clk),
    .rst           (rst),
    .i_mem_valid   (mem_valid),
    .i_mem_read    (mem_read),
    .i_mem_write   (mem_write),
    .i_funct3      (funct3),
    .i_addr        (addr),
    .i_store_data  (store_data),
    .i_pipe_advance(pipe_advance),
    .dmem          (dmem_if),
    .o_stall       (stall),
    .o_mem_rdata   (mem_rdata),
    .o_bit_shift   (bit_shift),
    .o_rmask       (rmask),
    .o_wmask       (wmask),
    .o_trap        (trap),
    .o_timeout_err (timeout_err),
    .o_state       (state)
  );

  always #5 clk = ~clk;

  // ---------------- model state / scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] exp_q[$];

  logic        e_check = 1'b0, e_pop = 1'b0;
  logic        e_stall, e_rd, e_wr, e_trap, e_err;
  logic [3:0]  e_rmask, e_wmask, e_be;
  logic [1:0]  e_shift;
  logic [31:0] e_addr, e_wdata, e_hold;
  mem_ctrl_state_t e_state;

  int          run_len = 0, last_run = 0;
  logic [31:0] seen_rd_addr, seen_wr_addr, seen_wdata;
  logic [3:0]  seen_rd_rmask, seen_wr_be, seen_wr_wmask, last_rmask;
  logic        last_trap, last_req, last_stall;

  logic [2:0] ld_f3 [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // access size in bytes from funct3
  function automatic int m_bytes(input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   return 1;
      2'b01:   return 2;
      default: return 4;
    endcase
  endfunction

  function automatic logic m_mis(input logic [2:0] f3, input logic [31:0] a);
    return (int'(a[1:0]) % m_bytes(f3)) != 0;
  endfunction

  function automatic logic [3:0] m_mask(input logic [2:0] f3, input logic [31:0] a);
    int b;
    b = m_bytes(f3);
    if (m_mis(f3, a)) return 4'b0000;
    return 4'(((1 << b) - 1) << int'(a[1:0]));
  endfunction

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (e_check) begin
      chk("stall",       32'(stall),              32'(e_stall));
      chk("dmem_read",   32'(dmem_if.dmem_read),  32'(e_rd));
      chk("dmem_write",  32'(dmem_if.dmem_write), 32'(e_wr));
      chk("trap",        32'(trap),               32'(e_trap));
      chk("rmask",       32'(rmask),              32'(e_rmask));
      chk("wmask",       32'(wmask),              32'(e_wmask));
      chk("bit_shift",   32'(bit_shift),          32'(e_shift));
      chk("timeout_err", 32'(timeout_err),        32'(e_err));
      chk("state",       32'(state),              32'(e_state));
      if (e_rd || e_wr) begin
        chk("dmem_address", dmem_if.dmem_address,          e_addr);
        chk("dmem_wdata",   dmem_if.dmem_wdata,            e_wdata);
        chk("dmem_be",      32'(dmem_if.dmem_byte_enable), 32'(e_be));
      end
      if (e_pop) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL exp_q: got empty queue expected one response at %0t", $time);
        end else begin
          e_hold = exp_q.pop_front();
        end
      end
      chk("mem_rdata", mem_rdata, e_hold);
      if (stall) run_len++;
      else begin
        if (run_len != 0) last_run = run_len;
        run_len = 0;
      end
      if (dmem_if.dmem_read) begin
        seen_rd_addr  = dmem_if.dmem_address;
        seen_rd_rmask = rmask;
      end
      if (dmem_if.dmem_write) begin
        seen_wr_addr  = dmem_if.dmem_address;
        seen_wdata    = dmem_if.dmem_wdata;
        seen_wr_be    = dmem_if.dmem_byte_enable;
        seen_wr_wmask = wmask;
      end
      last_trap  = trap;
      last_rmask = rmask;
      last_req   = dmem_if.dmem_read | dmem_if.dmem_write;
      last_stall = stall;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One MEM-stage instruction: issue at cycle 0, cache answers at cycle k,
  // then `hold` DONE cycles with pipe_advance low before it advances.
  task automatic do_op(input logic v, input logic rd, input logic wr, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] sd, input logic [31:0] rdata,
                       input int k, input int hold, input logic stray);
    logic mis, go;
    mis = m_mis(f3, a);
    go  = v && (rd || wr) && !mis;
    mem_valid = v; mem_read = rd; mem_write = wr;
    funct3 = f3; addr = a; store_data = sd;
    pipe_advance = 1'b0;
    e_rmask = (rd && !mis) ? m_mask(f3, a) : 4'b0000;
    e_wmask = (wr && !mis) ? m_mask(f3, a) : 4'b0000;
    e_trap  = v && (rd || wr) && mis;
    e_shift = a[1:0];
    e_state = IDLE;
    e_pop   = 1'b0;
    e_check = 1'b1;
    if (!go) begin
      e_rd = 1'b0; e_wr = 1'b0; e_stall = 1'b0;
      pipe_advance = 1'b1;
      if (stray) begin
        dmem_if.dmem_resp  = 1'b1;
        dmem_if.dmem_rdata = rdata;
      end
      step();
      dmem_if.dmem_resp = 1'b0;
    end else begin
      e_rd = rd; e_wr = wr;
      e_addr  = a & 32'hFFFF_FFFC;
      e_wdata = 32'(sd << (8 * int'(a[1:0])));
      e_be    = wr ? e_wmask : 4'b1111;
      e_stall = 1'b1;
      for (int c = 0; c <= k; c++) begin
        e_state = (c == 0) ? IDLE : BUSY;
        if (TMO != 0 && c - 1 >= TMO) e_err = 1'b1;
        if (c == k) begin
          dmem_if.dmem_resp  = 1'b1;
          dmem_if.dmem_rdata = rdata;
          exp_q.push_back(rdata);
        end
        step();
      end
      dmem_if.dmem_resp  = 1'b0;
      dmem_if.dmem_rdata = $urandom;
      if (TMO != 0 && k >= TMO) e_err = 1'b1;
      e_rd = 1'b0; e_wr = 1'b0; e_stall = 1'b0;
      e_state = DONE;
      for (int h = 0; h <= hold; h++) begin
        e_pop = (h == 0);
        pipe_advance = (h == hold);
        step();
      end
      e_pop = 1'b0;
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic v, rd, wr;
    logic [2:0] f3;
    int kind;
    e_hold = '0; e_err = 1'b0;
    mem_valid = 0; mem_read = 0; mem_write = 0; pipe_advance = 0;
    funct3 = '0; addr = '0; store_data = '0;
    dmem_if.dmem_resp = 1'b0; dmem_if.dmem_rdata = '0;
    rst = 1'b1;
    #1 rst = 1'b0;
    #2;
    chk("reset_state",     32'(state),             32'(IDLE));
    chk("reset_stall",     32'(stall),             32'd0);
    chk("reset_read",      32'(dmem_if.dmem_read), 32'd0);
    chk("reset_write",     32'(dmem_if.dmem_write),32'd0);
    chk("reset_mem_rdata", mem_rdata,              32'd0);
    chk("reset_timeout",   32'(timeout_err),       32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;

    // LW 0x100, response after 3 cycles
    do_op(1, 1, 0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 3, 0, 0);
    chk("pin_lw_stall_run", 32'(last_run),      32'd4);
    chk("pin_lw_addr",      seen_rd_addr,       32'h100);
    chk("pin_lw_rmask",     32'(seen_rd_rmask), 32'hF);
    chk("pin_lw_rdata",     mem_rdata,          32'hDEADBEEF);

    // SB 0x203
    do_op(1, 0, 1, 3'b000, 32'h203, 32'h000000AB, 32'h0, 2, 0, 0);
    chk("pin_sb_addr",  seen_wr_addr,       32'h200);
    chk("pin_sb_wdata", seen_wdata,         32'hAB000000);
    chk("pin_sb_be",    32'(seen_wr_be),    32'h8);
    chk("pin_sb_wmask", 32'(seen_wr_wmask), 32'h8);

    // misaligned LH 0x101 and LW 0x102
    do_op(1, 1, 0, 3'b001, 32'h101, 32'h0, 32'h0, 1, 0, 0);
    chk("pin_lh_trap",  32'(last_trap),  32'd1);
    chk("pin_lh_rmask", 32'(last_rmask), 32'd0);
    chk("pin_lh_req",   32'(last_req),   32'd0);
    chk("pin_lh_stall", 32'(last_stall), 32'd0);
    do_op(1, 1, 0, 3'b010, 32'h102, 32'h0, 32'h0, 1, 0, 0);
    chk("pin_lw_mis_trap", 32'(last_trap), 32'd1);
    chk("pin_lw_mis_req",  32'(last_req),  32'd0);

    // response held while pipe_advance stays low for 2 cycles
    do_op(1, 1, 0, 3'b010, 32'h480, 32'h0, 32'h12345678, 2, 2, 0);
    chk("pin_hold_rdata", mem_rdata, 32'h12345678);

    // stray response while idle must be ignored
    do_op(0, 0, 0, 3'b000, 32'h0, 32'h0, 32'hCAFEF00D, 1, 0, 1);
    do_op(0, 0, 0, 3'b000, 32'h0, 32'h0, 32'h0, 1, 0, 0);
    chk("pin_stray_rdata", mem_rdata, 32'h12345678);

    // back-to-back LBU 0x301 then SW 0x304
    do_op(1, 1, 0, 3'b100, 32'h301, 32'h0, 32'h55667788, 1, 0, 0);
    do_op(1, 0, 1, 3'b010, 32'h304, 32'hA5A5_5A5A, 32'h0, 1, 0, 0);
    chk("pin_lbu_rmask", 32'(seen_rd_rmask), 32'h2);
    chk("pin_sw_wmask",  32'(seen_wr_wmask), 32'hF);
    chk("pin_sw_be",     32'(seen_wr_be),    32'hF);

    // randomized traffic
    for (int n = 0; n < 200; n++) begin
      v = ($urandom_range(0, 9) != 0);
      rd = 1'b0; wr = 1'b0;
      kind = $urandom_range(0, 4);
      if (v && kind inside {[1:2]}) rd = 1'b1;
      if (v && kind inside {[3:4]}) wr = 1'b1;
      f3 = rd ? ld_f3[$urandom_range(0, 4)] : 3'($urandom_range(0, 2));
      do_op(v, rd, wr, f3, $urandom, $urandom, $urandom,
            $urandom_range(1, 3), $urandom_range(0, 2), ($urandom_range(0, 3) == 0));
    end

    // watchdog: LW with no response
    mem_valid = 1; mem_read = 1; mem_write = 0; funct3 = 3'b010;
    addr = 32'h40; store_data = '0; pipe_advance = 0;
    e_rd = 1; e_wr = 0; e_stall = 1; e_trap = 0; e_rmask = 4'hF; e_wmask = 4'h0;
    e_shift = 2'b00; e_addr = 32'h40; e_be = 4'hF; e_wdata = 32'h0; e_pop = 0;
    e_check = 1;
    for (int c = 0; c <= 7; c++) begin
      e_state = (c == 0) ? IDLE : BUSY;
      if (c - 1 >= TMO) e_err = 1'b1;
      step();
    end
    chk("pin_timeout_err", 32'(timeout_err),       32'd1);
    chk("pin_timeout_req", 32'(dmem_if.dmem_read), 32'd1);

    // asynchronous reset mid-cycle while BUSY
    e_check = 1'b0;
    #2 rst = 1'b0;
    #1;
    chk("arst_state",     32'(state),              32'(IDLE));
    chk("arst_stall",     32'(stall),              32'd0);
    chk("arst_read",      32'(dmem_if.dmem_read),  32'd0);
    chk("arst_write",     32'(dmem_if.dmem_write), 32'd0);
    chk("arst_timeout",   32'(timeout_err),        32'd0);
    chk("arst_mem_rdata", mem_rdata,               32'd0);
    mem_valid = 0; mem_read = 0;
    exp_q.delete();
    e_hold = '0; e_err = 1'b0; run_len = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;

    // recovery after reset
    do_op(1, 0, 1, 3'b001, 32'h802, 32'h0000BEEF, 32'h0BAD0BAD, 2, 1, 0);
    do_op(1, 1, 0, 3'b101, 32'h806, 32'h0, 32'h77778888, 1, 0, 0);
    e_check = 1'b0;
    step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
